// File: rtl/alu_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the shared ALU.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface alu_arbiter_if #(
  parameter int unsigned bus_size       = 4,
  parameter int unsigned shamt_bus_size = 2
);
  localparam int unsigned W = bus_size;
  localparam int unsigned S = shamt_bus_size + 1;

  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [2*W-1:0] req_a;
  logic [2*W-1:0] req_b;
  logic [5:0]     req_op;
  logic [2*S-1:0] req_shamt;

  logic [W-1:0]   alu_a;
  logic [W-1:0]   alu_b;
  logic [2:0]     alu_op;
  logic [S-1:0]   alu_shamt;
  logic [W-1:0]   alu_s;
  logic [3:0]     alu_flags;

  logic [1:0]     rsp_valid;
  logic [1:0]     rsp_ready;
  logic [W-1:0]   rsp_data;
  logic [3:0]     rsp_flags;
  logic           busy;

  modport slave (
    input  req_valid, req_a, req_b, req_op, req_shamt,
    input  alu_s, alu_flags,
    input  rsp_ready,
    output req_ready,
    output alu_a, alu_b, alu_op, alu_shamt,
    output rsp_valid, rsp_data, rsp_flags, busy
  );

  modport master (
    output req_valid, req_a, req_b, req_op, req_shamt,
    output alu_s, alu_flags,
    output rsp_ready,
    input  req_ready,
    input  alu_a, alu_b, alu_op, alu_shamt,
    input  rsp_valid, rsp_data, rsp_flags, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters:
// registers the granted operands, captures result/flags, holds them until consumed.
module alu_arbiter #(
  parameter int unsigned bus_size       = 4,
  parameter int unsigned shamt_bus_size = 2
) (
  input  logic         clk,
  input  logic         reset,
  alu_arbiter_if.slave bus
);
  localparam int unsigned W = bus_size;
  localparam int unsigned S = shamt_bus_size + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic         owner_q, owner_d;
  logic         last_q, last_d;
  logic [W-1:0] alu_a_q, alu_a_d;
  logic [W-1:0] alu_b_q, alu_b_d;
  logic [2:0]   alu_op_q, alu_op_d;
  logic [S-1:0] alu_shamt_q, alu_shamt_d;
  logic [W-1:0] rsp_data_q, rsp_data_d;
  logic [3:0]   rsp_flags_q, rsp_flags_d;
  logic [1:0]   rsp_valid_q, rsp_valid_d;
  logic         busy_q, busy_d;

  logic         grant;
  logic [1:0]   req_ready;
  logic [W-1:0] sel_a;
  logic [W-1:0] sel_b;
  logic [2:0]   sel_op;
  logic [S-1:0] sel_shamt;

  // Grant: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    grant = 1'b0;
    case (bus.req_valid)
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_q;
      default: grant = 1'b0;
    endcase

    req_ready = '0;
    if (reset && (state_q == IDLE) && (bus.req_valid != 2'b00)) begin
      req_ready = grant ? 2'b10 : 2'b01;
    end

    sel_a     = grant ? bus.req_a[2*W-1:W]     : bus.req_a[W-1:0];
    sel_b     = grant ? bus.req_b[2*W-1:W]     : bus.req_b[W-1:0];
    sel_op    = grant ? bus.req_op[5:3]        : bus.req_op[2:0];
    sel_shamt = grant ? bus.req_shamt[2*S-1:S] : bus.req_shamt[S-1:0];
  end

  // rsp_valid and busy are produced as flops from the next state so they
  // never depend combinationally on inputs.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    alu_shamt_d = alu_shamt_q;
    rsp_data_d  = rsp_data_q;
    rsp_flags_d = rsp_flags_q;
    rsp_valid_d = rsp_valid_q;
    busy_d      = busy_q;

    case (state_q)
      IDLE: begin
        if (req_ready != 2'b00) begin
          alu_a_d     = sel_a;
          alu_b_d     = sel_b;
          alu_op_d    = sel_op;
          alu_shamt_d = sel_shamt;
          owner_d     = grant;
          last_d      = grant;
          busy_d      = 1'b1;
          state_d     = EXEC;
        end
      end
      EXEC: begin
        rsp_data_d  = bus.alu_s;
        rsp_flags_d = bus.alu_flags;
        rsp_valid_d = owner_q ? 2'b10 : 2'b01;
        state_d     = RESP;
      end
      RESP: begin
        if (bus.rsp_ready[owner_q]) begin
          rsp_valid_d = '0;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        rsp_valid_d = '0;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      alu_shamt_q <= '0;
      rsp_data_q  <= '0;
      rsp_flags_q <= '0;
      rsp_valid_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      alu_shamt_q <= alu_shamt_d;
      rsp_data_q  <= rsp_data_d;
      rsp_flags_q <= rsp_flags_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_op    = alu_op_q;
  assign bus.alu_shamt = alu_shamt_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_flags = rsp_flags_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a behavioural ALU stands in for the shared ALU, and a
// transaction-level model predicts every output each cycle.
module tb_alu_arbiter;
  localparam int unsigned W = 4;
  localparam int unsigned S = 3;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  alu_arbiter_if #(.bus_size(W), .shamt_bus_size(S - 1)) bus ();

  alu_arbiter #(.bus_size(W), .shamt_bus_size(S - 1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Returns {overflow, zero, negative, carry, result}
  function automatic logic [7:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                        input logic [2:0] op, input logic [2:0] sh);
    logic [4:0] wide;
    logic [3:0] s;
    logic       v;
    wide = '0;
    v    = 1'b0;
    case (op)
      3'd0: begin
        wide = {1'b0, a} + {1'b0, b};
        v    = (a[3] == b[3]) && (wide[3] != a[3]);
      end
      3'd1: begin
        wide = {1'b0, a} + {1'b0, ~b} + 5'd1;
        v    = (a[3] != b[3]) && (wide[3] != a[3]);
      end
      3'd2:    wide = {1'b0, a & b};
      3'd3:    wide = {1'b0, a | b};
      3'd4:    wide = {1'b0, a ^ b};
      3'd5:    wide = {1'b0, a << sh};
      3'd6:    wide = {1'b0, a >> sh};
      default: wide = {1'b0, b};
    endcase
    s = wide[3:0];
    return {v, (s == 4'd0), s[3], wide[4], s};
  endfunction

  always_comb begin
    {bus.alu_flags, bus.alu_s} = alu_fn(bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_shamt);
  end

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: one transaction at a time, aged in cycles since its grant.
  logic        m_inflight;
  int unsigned m_age;
  logic        m_owner;
  logic        m_last;
  logic [13:0] m_alu;
  logic [7:0]  m_pending;
  logic [7:0]  m_rsp;

  typedef struct {
    int unsigned cyc;
    logic        g;
  } hs_t;
  hs_t hs_log[$];

  task automatic model_reset();
    m_inflight = 1'b0;
    m_age      = 0;
    m_owner    = 1'b0;
    m_last     = 1'b1;
    m_alu      = '0;
    m_pending  = '0;
    m_rsp      = '0;
  endtask

  task automatic tick();
    logic [1:0]  e_ready;
    logic [1:0]  e_rsp_valid;
    logic        g;
    logic [3:0]  a;
    logic [3:0]  b;
    logic [2:0]  op;
    logic [2:0]  sh;
    logic        n_inflight;
    int unsigned n_age;
    logic        n_owner;
    logic        n_last;
    logic [13:0] n_alu;
    logic [7:0]  n_pending;
    logic [7:0]  n_rsp;
    @(negedge clk);
    g       = 1'b0;
    e_ready = 2'b00;
    if (reset && !m_inflight && bus.req_valid != 2'b00) begin
      if (bus.req_valid == 2'b11) g = ~m_last;
      else                        g = bus.req_valid[1];
      e_ready = g ? 2'b10 : 2'b01;
    end
    e_rsp_valid = (m_inflight && m_age >= 2) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
    check("req_ready", {30'd0, bus.req_ready}, {30'd0, e_ready});
    check("busy", {31'd0, bus.busy}, {31'd0, m_inflight});
    check("rsp_valid", {30'd0, bus.rsp_valid}, {30'd0, e_rsp_valid});
    check("alu_in", {18'd0, bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_shamt}, {18'd0, m_alu});
    check("rsp", {24'd0, bus.rsp_flags, bus.rsp_data}, {24'd0, m_rsp});
    if (bus.req_ready != 2'b00) hs_log.push_back('{cyc: cyc, g: bus.req_ready[1]});

    n_inflight = m_inflight; n_age = m_age; n_owner = m_owner; n_last = m_last;
    n_alu = m_alu; n_pending = m_pending; n_rsp = m_rsp;
    if (e_ready != 2'b00) begin
      a  = g ? bus.req_a[7:4]     : bus.req_a[3:0];
      b  = g ? bus.req_b[7:4]     : bus.req_b[3:0];
      op = g ? bus.req_op[5:3]    : bus.req_op[2:0];
      sh = g ? bus.req_shamt[5:3] : bus.req_shamt[2:0];
      n_inflight = 1'b1; n_age = 1; n_owner = g; n_last = g;
      n_alu      = {a, b, op, sh};
      n_pending  = alu_fn(a, b, op, sh);
    end else if (m_inflight) begin
      if (m_age == 1) begin
        n_age = 2;
        n_rsp = m_pending;
      end else if (bus.rsp_ready[m_owner]) begin
        n_inflight = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    if (!reset) begin
      model_reset();
    end else begin
      m_inflight = n_inflight; m_age = n_age; m_owner = n_owner; m_last = n_last;
      m_alu = n_alu; m_pending = n_pending; m_rsp = n_rsp;
    end
    cyc++;
  endtask

  task automatic set_req(input int unsigned i, input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] op, input logic [2:0] sh);
    if (i == 0) begin
      bus.req_a[3:0] = a; bus.req_b[3:0] = b; bus.req_op[2:0] = op; bus.req_shamt[2:0] = sh;
    end else begin
      bus.req_a[7:4] = a; bus.req_b[7:4] = b; bus.req_op[5:3] = op; bus.req_shamt[5:3] = sh;
    end
  endtask

  logic [7:0] held;

  initial begin
    bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0;
    bus.req_op = '0; bus.req_shamt = '0; bus.rsp_ready = '0;
    model_reset();
    repeat (2) tick();
    reset = 1'b1;

    // Simple ADD from requester 0
    set_req(0, 4'd3, 4'd5, 3'd0, 3'd0);
    bus.req_valid = 2'b01;
    #1 check("t1_ready", {30'd0, bus.req_ready}, 32'h1);
    tick();
    check("t1_alu_a", {28'd0, bus.alu_a}, 32'd3);
    check("t1_alu_b", {28'd0, bus.alu_b}, 32'd5);
    bus.req_valid = 2'b00;
    tick();
    check("t1_rsp_valid", {30'd0, bus.rsp_valid}, 32'h1);
    check("t1_rsp_data", {28'd0, bus.rsp_data}, 32'd8);
    check("t1_zero_carry", {30'd0, bus.rsp_flags[2], bus.rsp_flags[0]}, 32'd0);
    bus.rsp_ready = 2'b01;
    tick();
    bus.rsp_ready = 2'b00;

    // Signed overflow from requester 1
    set_req(1, 4'd7, 4'd1, 3'd0, 3'd0);
    bus.req_valid = 2'b10;
    tick();
    bus.req_valid = 2'b00;
    tick();
    check("ovf_rsp_valid", {30'd0, bus.rsp_valid}, 32'h2);
    check("ovf_rsp_data", {28'd0, bus.rsp_data}, 32'd8);
    check("ovf_v_n", {30'd0, bus.rsp_flags[3], bus.rsp_flags[1]}, 32'h3);
    bus.rsp_ready = 2'b10;
    tick();
    bus.rsp_ready = 2'b00;

    // Back-pressure on the response while requester 0 keeps asking
    set_req(0, 4'd9, 4'd3, 3'd1, 3'd0);
    bus.req_valid = 2'b01;
    tick();
    tick();
    held = {bus.rsp_flags, bus.rsp_data};
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_stable", {24'd0, bus.rsp_flags, bus.rsp_data}, {24'd0, held});
      check("bp_ready", {30'd0, bus.req_ready}, 32'd0);
      check("bp_busy", {31'd0, bus.busy}, 32'd1);
    end
    bus.rsp_ready = 2'b01;
    tick();
    check("bp_regrant", {30'd0, bus.req_ready}, 32'h1);
    bus.rsp_ready = 2'b00;
    tick();
    bus.req_valid = 2'b00;
    tick();
    bus.rsp_ready = 2'b01;
    tick();
    bus.rsp_ready = 2'b00;

    // Reset while an operation is in EXEC
    set_req(0, 4'd2, 4'd2, 3'd0, 3'd0);
    bus.req_valid = 2'b01;
    tick();
    set_req(1, 4'd1, 4'd1, 3'd0, 3'd0);
    bus.req_valid = 2'b11;
    #2 reset = 1'b0;
    #1;
    model_reset();
    check("rst_outputs", {bus.req_ready, bus.busy, bus.rsp_valid, bus.alu_a, bus.alu_b,
                          bus.alu_op, bus.alu_shamt, bus.rsp_data, bus.rsp_flags}, 32'd0);
    tick();
    tick();
    reset = 1'b1;
    #1 check("rst_first_grant", {30'd0, bus.req_ready}, 32'h1);
    tick();
    bus.req_valid = 2'b00;
    tick();
    bus.rsp_ready = 2'b11;
    tick();
    bus.rsp_ready = 2'b00;

    // Continuous contention: grants alternate, three cycles apart
    #2 reset = 1'b0;
    #1 model_reset();
    tick();
    reset = 1'b1;
    hs_log.delete();
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b11;
    repeat (12) tick();
    check("rr_count_ge4", {31'd0, hs_log.size() >= 4}, 32'd1);
    if (hs_log.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        check("rr_order", {31'd0, hs_log[i].g}, (i % 2 == 1) ? 32'd1 : 32'd0);
        if (i > 0) check("rr_spacing", hs_log[i].cyc - hs_log[i-1].cyc, 32'd3);
      end
    end
    bus.req_valid = 2'b00;
    repeat (3) tick();
    bus.rsp_ready = 2'b00;

    // Short-lived request while busy, then a shift by 4
    set_req(0, 4'd5, 4'd3, 3'd4, 3'd0);
    bus.req_valid = 2'b01;
    tick();
    set_req(1, 4'd3, 4'd0, 3'd5, 3'd4);
    bus.req_valid = 2'b11;
    tick();
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b01;
    tick();
    bus.rsp_ready = 2'b00;
    check("sh_not_recorded", {29'd0, bus.alu_op}, 32'd4);
    bus.req_valid = 2'b10;
    tick();
    check("sh_alu_shamt", {29'd0, bus.alu_shamt}, 32'd4);
    bus.req_valid = 2'b00;
    tick();
    check("sh_rsp", {24'd0, bus.rsp_flags, bus.rsp_data}, 32'h40);
    bus.rsp_ready = 2'b10;
    tick();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      bus.req_valid = 2'($urandom_range(0, 3));
      bus.req_a     = 8'($urandom);
      bus.req_b     = 8'($urandom);
      bus.req_op    = 6'($urandom);
      bus.req_shamt = 6'($urandom);
      bus.rsp_ready = 2'($urandom_range(0, 3));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational ALU (operands `a`/`b`, 3-bit select, shift amount, four flags) between two requesters. Requester traffic uses valid/ready handshakes. The block grants requesters round-robin, registers the granted operands onto the ALU inputs, captures the result and flags one cycle later, and holds them on a per-requester response handshake. It sits between the execution-unit front ends and the shared ALU instance; the ALU itself is outside this block.

## Interface
Parameters:
- `bus_size`, 4, operand/result width
- `shamt_bus_size`, 2, shift field width is `shamt_bus_size+1` (extra MSB keeps the value unsigned)

Ports (`W = bus_size`, `S = shamt_bus_size+1`; requester i occupies slice `[i*n +: n]`):
- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low; clears all state immediately
- `req_valid`  in  2  request valid, bit i = requester i
- `req_ready`  out  2  request accepted this cycle (one-hot or zero)
- `req_a`, `req_b`  in  2*W  operands
- `req_op`  in  6  3-bit ALU select per requester
- `req_shamt`  in  2*S  shift amount per requester
- `alu_a`, `alu_b`  out  W  registered operands to ALU
- `alu_op`  out  3  registered select to ALU
- `alu_shamt`  out  S  registered shift to ALU
- `alu_s`  in  W  ALU result
- `alu_flags`  in  4  {overflow, zero, negative, carry_out}
- `rsp_valid`  out  2  response valid, one-hot to the owning requester
- `rsp_ready`  in  2  response consumed
- `rsp_data`  out  W  captured result
- `rsp_flags`  out  4  captured flags, same order as `alu_flags`
- `busy`  out  1  high in EXEC or RESP

## Operation
- FSM states: IDLE, EXEC, RESP. Registers: `state`, `owner` (1 bit), `last` (1 bit, last granted), ALU input registers, response registers.
- IDLE:
  - Grant `g` is computed combinationally from `req_valid`. If only one requester is valid, it is granted. If both are valid, the grant goes to `!last`.
  - `req_ready[g]` = 1 only in IDLE with `req_valid[g]`=1.
  - On handshake, `req_*[g]` are loaded into `alu_*`, `owner`←g, `last`←g, and the FSM moves to EXEC.
- EXEC (exactly one cycle):
  - `rsp_data`←`alu_s`, `rsp_flags`←`alu_flags`.
  - The FSM moves to RESP.
- RESP:
  - `rsp_valid[owner]`=1; `rsp_data` and `rsp_flags` are held stable.
  - When `rsp_ready[owner]`=1, the FSM returns to IDLE.
  - `rsp_ready` of the non-owner is ignored.
- `alu_*` registers hold their last value outside IDLE handshakes; they are not cleared on completion.
- `req_op` and `req_shamt` values are passed through unchecked. Undefined opcodes are the ALU's concern.
- A requester may drop `req_valid` without a handshake; no request is committed until `req_ready`=1.
- There is no pipelining: at most one operation is in flight.

## Timing
- Reset (`reset`=0, asynchronous):
  - state=IDLE, `last`=1 so requester 0 wins the first tie, `owner`=0.
  - `alu_a`, `alu_b`, `alu_op`, `alu_shamt`, `rsp_data`, `rsp_flags` are all 0.
  - `rsp_valid`=0, `req_ready`=0, `busy`=0.
- Reset mid-operation aborts the operation. The in-flight result is discarded, no response is issued, and `last` returns to 1.
- Latency:
  - Handshake at edge N: `alu_*` valid after N, result captured at N+1.
  - `rsp_valid` goes high in the cycle after N+1.
  - With `rsp_ready` tied to 1, the next grant occurs at edge N+3 at the earliest. Peak throughput is one operation per 3 cycles.
- `req_ready` is combinational from `state` and `req_valid`. `rsp_valid` and `busy` are decoded from registered state only.
- Requests arriving during EXEC or RESP wait with `req_ready`=0. Arbitration runs on the first IDLE cycle.
- `rsp_ready` high before `rsp_valid` has no effect.

## Test plan
- Reset, then req0 only: a=3, b=5, op=ADD select -> `req_ready`=01 in the same cycle; `alu_a`=3, `alu_b`=5 next cycle; `rsp_valid`=01, `rsp_data`=8, zero=0, carry=0 two cycles after the handshake.
- Both valid continuously, `rsp_ready`=11 -> grants alternate 0,1,0,1; the first grant after reset goes to 0; each grant is 3 cycles apart.
- Overflow: req1 with a=7, b=1, ADD (W=4) -> `rsp_valid`=10, `rsp_data`=8, overflow=1, negative=1.
- Back-pressure: hold `rsp_ready`=0 for 5 cycles while req0 is valid -> `rsp_data` is stable, `req_ready`=00, `busy`=1 throughout. Release -> return to IDLE, then req0 is granted.
- `reset`=0 asserted during EXEC -> all outputs are 0 immediately and no `rsp_valid` pulse occurs. After release with both valid -> requester 0 is granted.
- Shift with shamt=4 (S=3, unsigned), req1 valid for only one cycle while the FSM is busy -> no handshake occurs for req1 and nothing is recorded. A later valid request is served normally with `alu_shamt`=4.
